// File: rtl/bf_resp_checker_pkg.sv
// Shared types and constants for the boolean-function response checker.
// Optional build macro: BF_RESP_CHECKER_HALT_ON_ERR_EN (see bf_resp_checker).
package bf_chk_pkg;

  localparam int VEC_W     = 3;
  localparam int LUT_DEPTH = 8;

  localparam logic [LUT_DEPTH-1:0] MAJ3_TT = 8'hE8;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bf_resp_checker_if.sv
// Control, observed-signal and result bundle of the response checker.
// master = stimulus/observer side, slave = checker.
interface bf_resp_checker_if #(
  parameter int CNT_W = 16
);
  import bf_chk_pkg::*;

  logic             start;
  logic             stop;
  logic             a;
  logic             b;
  logic             c;
  logic             x;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [7:0]       cov;
  vec_t             first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, stop, a, b, c, x,
    input  busy, done, pass,
    input  chk_cnt, err_cnt, cov,
    input  first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, stop, a, b, c, x,
    output busy, done, pass,
    output chk_cnt, err_cnt, cov,
    output first_fail_vec, first_fail_valid
  );

endinterface

// File: rtl/bf_resp_checker_stable.sv
// Samples {a,b,c,x} and emits one chk_evt per window stable for SETTLE
// cycles; clr restarts the stability count.
module bf_chk_stable
  import bf_chk_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic x,
  output vec_t vec,
  output logic x_s,
  output logic chk_evt
);

  localparam logic [3:0] SET_C = 4'(SETTLE);

  logic [3:0] samp_q, samp_d;
  logic [3:0] stab_q, stab_d;
  logic       evt_q, evt_d;

  always_comb begin
    samp_d = {a, b, c, x};
    stab_d = stab_q;
    if (clr || samp_d != samp_q) begin
      stab_d = '0;
    end else if (stab_q != SET_C) begin
      stab_d = stab_q + 4'd1;
    end
    // fire only on the edge the count first reaches SETTLE
    evt_d = (stab_d == SET_C) && (stab_q != SET_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= '0;
      stab_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      samp_q <= samp_d;
      stab_q <= stab_d;
      evt_q  <= evt_d;
    end
  end

  assign vec     = samp_q[3:1];
  assign x_s     = samp_q[0];
  assign chk_evt = evt_q;

endmodule

// File: rtl/bf_resp_checker.sv
// Judges a 3-input boolean function against TRUTH_TABLE.
// Macro BF_RESP_CHECKER_HALT_ON_ERR_EN: first mismatch ends the run.
module bf_resp_checker
  import bf_chk_pkg::*;
#(
  parameter logic [7:0] TRUTH_TABLE = MAJ3_TT,
  parameter int         SETTLE      = 2,
  parameter int         CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  bf_resp_checker_if.slave  bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [7:0]       cov_q, cov_d;
  vec_t             ffv_q, ffv_d;
  logic             ffval_q, ffval_d;
  logic             pass_q, pass_d;

  vec_t vec;
  logic x_s;
  logic chk_evt;
  logic mis;

  bf_chk_stable #(
    .SETTLE (SETTLE)
  ) u_stable (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.start),
    .a       (bus.a),
    .b       (bus.b),
    .c       (bus.c),
    .x       (bus.x),
    .vec     (vec),
    .x_s     (x_s),
    .chk_evt (chk_evt)
  );

  assign mis = x_s != TRUTH_TABLE[vec];

  always_comb begin
    state_d = state_q;
    chk_d   = chk_q;
    err_d   = err_q;
    cov_d   = cov_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    if (bus.start) begin
      state_d = ST_RUN;
      chk_d   = '0;
      err_d   = '0;
      cov_d   = '0;
      ffval_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (chk_evt) begin
        if (chk_q != '1) chk_d = chk_q + CNT_W'(1);
        cov_d[vec] = 1'b1;
        if (mis) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (!ffval_q) begin
            ffv_d   = vec;
            ffval_d = 1'b1;
          end
        end
      end
      if (bus.stop || chk_d == '1) state_d = ST_DONE;
`ifdef BF_RESP_CHECKER_HALT_ON_ERR_EN
      if (chk_evt && mis) state_d = ST_DONE;
`endif
    end
    pass_d = (state_d == ST_DONE) && (err_d == '0) &&
             (cov_d == 8'hFF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chk_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.busy             = state_q == ST_RUN;
  assign bus.done             = state_q == ST_DONE;
  assign bus.pass             = pass_q;
  assign bus.chk_cnt          = chk_q;
  assign bus.err_cnt          = err_q;
  assign bus.cov              = cov_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffval_q;

endmodule

// File: tb/tb_bf_resp_checker.sv
// Randomized + directed bench for bf_resp_checker with a window-level model.
// Honors BF_RESP_CHECKER_HALT_ON_ERR_EN when defined at compile time.
module tb_bf_resp_checker;
  import bf_chk_pkg::*;

  localparam int SETTLE = 2;
`ifdef BF_RESP_CHECKER_HALT_ON_ERR_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bf_resp_checker_if #(.CNT_W(16)) bus ();

  bf_resp_checker #(
    .TRUTH_TABLE (8'hE8),
    .SETTLE      (SETTLE),
    .CNT_W       (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int wv[$];
  bit wx[$];
  int wn[$];

  int       e_chk, e_err, e_ffv;
  bit       e_ffval, e_pass;
  bit [7:0] e_cov;

  function automatic bit maj(int v);
    return $countones(v[2:0]) >= 2;
  endfunction

  task automatic set_in(int v, bit xv);
    bus.a = v[2];
    bus.b = v[1];
    bus.c = v[0];
    bus.x = xv;
  endtask

  task automatic add_win(int v, bit xv, int n);
    wv.push_back(v);
    wx.push_back(xv);
    wn.push_back(n);
  endtask

  // A window held for n edges is judged once if n > SETTLE.
  task automatic model();
    bit halted = 1'b0;
    int len;
    e_chk = 0; e_err = 0; e_cov = '0;
    e_ffv = 0; e_ffval = 1'b0;
    foreach (wv[i]) begin
      len = wn[i] + ((i == wv.size() - 1) ? 5 : 0);
      if (!halted && len >= SETTLE + 1) begin
        e_chk++;
        e_cov[wv[i]] = 1'b1;
        if (wx[i] != maj(wv[i])) begin
          e_err++;
          if (!e_ffval) begin
            e_ffv = wv[i];
            e_ffval = 1'b1;
          end
          if (HALT) halted = 1'b1;
        end
      end
    end
    e_pass = (e_err == 0) && (e_cov == 8'hFF);
  endtask

  task automatic play();
    @(negedge clk);
    foreach (wv[i]) begin
      set_in(wv[i], wx[i]);
      bus.start = (i == 0);
      repeat (wn[i]) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.chk_cnt, bus.err_cnt,
         bus.cov, bus.first_fail_vec, bus.first_fail_valid} !== '0) begin
      failures++;
      $display("FAIL reset outs got busy%0b done%0b chk%0d cov%h",
               bus.busy, bus.done, bus.chk_cnt, bus.cov);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    set_in(2, 1'b1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.chk_cnt !== 16'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL lat_early got chk=%0d busy=%0b exp 0 1",
               bus.chk_cnt, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.chk_cnt !== 16'd1 || bus.err_cnt !== 16'd1 ||
        bus.done !== HALT) begin
      failures++;
      $display("FAIL lat_edge got chk=%0d err=%0d done=%0b exp 1 1 %0b",
               bus.chk_cnt, bus.err_cnt, bus.done, HALT);
    end
    set_in(5, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (bus.err_cnt !== (HALT ? 16'd1 : 16'd2)) begin
      failures++;
      $display("FAIL lat_later err got %0d exp %0d",
               bus.err_cnt, HALT ? 1 : 2);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic test_walk();
    wv.delete(); wx.delete(); wn.delete();
    for (int v = 0; v < 8; v++) add_win(v, maj(v), 10);
    play();
    checks++;
    if (bus.chk_cnt !== 16'd8 || bus.err_cnt !== 16'd0 ||
        bus.cov !== 8'hFF || bus.first_fail_valid !== 1'b0) begin
      failures++;
      $display("FAIL walk got chk=%0d err=%0d cov=%h ffv=%0b exp 8 0 ff 0",
               bus.chk_cnt, bus.err_cnt, bus.cov, bus.first_fail_valid);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL walk_flags got done=%0b pass=%0b busy=%0b exp 1 1 0",
               bus.done, bus.pass, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.chk_cnt !== 16'd8) begin
      failures++;
      $display("FAIL stop_in_done got done=%0b chk=%0d exp 1 8",
               bus.done, bus.chk_cnt);
    end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.chk_cnt !== 16'd0 ||
        bus.cov !== 8'h00 || bus.pass !== 1'b0) begin
      failures++;
      $display("FAIL start_stop got busy=%0b chk=%0d cov=%h pass=%0b",
               bus.busy, bus.chk_cnt, bus.cov, bus.pass);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic test_mismatch();
    wv.delete(); wx.delete(); wn.delete();
    for (int v = 0; v < 8; v++)
      add_win(v, (v == 1) ? 1'b1 : maj(v), 10);
    play();
    checks++;
    if (bus.chk_cnt !== (HALT ? 16'd2 : 16'd8) ||
        bus.err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL mis_cnt got chk=%0d err=%0d exp %0d 1",
               bus.chk_cnt, bus.err_cnt, HALT ? 2 : 8);
    end
    checks++;
    if (bus.first_fail_vec !== 3'b001 ||
        bus.first_fail_valid !== 1'b1 || bus.pass !== 1'b0) begin
      failures++;
      $display("FAIL mis_ff got vec=%0d val=%0b pass=%0b exp 1 1 0",
               bus.first_fail_vec, bus.first_fail_valid, bus.pass);
    end
  endtask

  task automatic test_glitch();
    wv.delete(); wx.delete(); wn.delete();
    add_win(0, 1'b0, 10);
    add_win(7, 1'b1, 1);
    add_win(0, 1'b0, 10);
    play();
    checks++;
    if (bus.chk_cnt !== 16'd2 || bus.cov !== 8'h01) begin
      failures++;
      $display("FAIL glitch got chk=%0d cov=%h exp 2 01",
               bus.chk_cnt, bus.cov);
    end
  endtask

  task automatic test_partial();
    wv.delete(); wx.delete(); wn.delete();
    for (int v = 0; v < 4; v++) add_win(v, maj(v), 10);
    play();
    checks++;
    if (bus.cov !== 8'h0F || bus.err_cnt !== 16'd0 ||
        bus.pass !== 1'b0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL partial got cov=%h err=%0d pass=%0b done=%0b",
               bus.cov, bus.err_cnt, bus.pass, bus.done);
    end
  endtask

  task automatic test_random();
    int v, pv;
    bit xv, px;
    for (int r = 0; r < 6; r++) begin
      wv.delete(); wx.delete(); wn.delete();
      pv = -1; px = 1'b0;
      for (int i = 0; i < 14; i++) begin
        do begin
          v  = $urandom_range(0, 7);
          xv = maj(v) ^ ($urandom_range(0, 3) == 0);
        end while (v == pv && xv == px);
        add_win(v, xv, $urandom_range(1, 6));
        pv = v; px = xv;
      end
      model();
      play();
      checks++;
      if (bus.chk_cnt !== 16'(e_chk) || bus.err_cnt !== 16'(e_err) ||
          bus.cov !== e_cov) begin
        failures++;
        $display("FAIL rnd%0d cnt got chk=%0d err=%0d cov=%h exp %0d %0d %h",
                 r, bus.chk_cnt, bus.err_cnt, bus.cov, e_chk, e_err, e_cov);
      end
      checks++;
      if (bus.first_fail_valid !== e_ffval ||
          (e_ffval && bus.first_fail_vec !== 3'(e_ffv)) ||
          bus.pass !== e_pass || bus.done !== 1'b1) begin
        failures++;
        $display("FAIL rnd%0d res got val=%0b vec=%0d pass=%0b exp %0b %0d %0b",
                 r, bus.first_fail_valid, bus.first_fail_vec, bus.pass,
                 e_ffval, e_ffv, e_pass);
      end
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      set_in(v, maj(v));
      bus.start = (v == 0);
      repeat (6) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.chk_cnt !== 16'd5 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre got chk=%0d busy=%0b exp 5 1",
               bus.chk_cnt, bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.pass, bus.chk_cnt, bus.err_cnt,
         bus.cov, bus.first_fail_vec, bus.first_fail_valid} !== '0) begin
      failures++;
      $display("FAIL rst_mid got busy=%0b chk=%0d cov=%h exp all 0",
               bus.busy, bus.chk_cnt, bus.cov);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.chk_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_idle got busy=%0b chk=%0d exp 0 0",
               bus.busy, bus.chk_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_in(0, 1'b0);
    test_reset();
    test_latency();
    test_walk();
    test_back_to_back();
    test_mismatch();
    test_glitch();
    test_partial();
    test_random();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
